serial_frame_rx: RTL
====================

// Module: serial_frame_rx
// PURPOSE
//   Receiving end of the board's serial shift link (clk/data/latch/clear). The
//   Display (SEGCLK/SEGDT/SEGEN/SEGCLR) and GPIO (LEDCLK/LEDDT/LEDEN/LEDCLR)
//   transmitters both drive this link.
//   Oversamples the four link wires on the system clock and deserializes MSB-first
//   frames into a parallel register, so a core can recover what the SoC shifted out.
//   Also flags malformed frames and counts good ones. Used as a sink for
//   self-check and loopback on the board.
// PARAMETERS
//   WIDTH    64      frame length in bits (64 = segment chain, 16 = LED chain)
//   CNT_W    7       bit counter width; must satisfy 2**CNT_W > WIDTH+1
//   TIMEOUT  100000  idle clk cycles inside a partial frame before it is abandoned
// PORTS
//   clk          in   1      system clock (100 MHz)
//   RSTN         in   1      asynchronous reset, active low
//   sclk         in   1      link shift clock (async to clk)
//   sdat         in   1      link serial data, MSB first
//   sen          in   1      link latch strobe, rising edge ends a frame
//   sclrn        in   1      link clear, active low, level sensitive
//   dout         out  WIDTH  last good frame
//   frame_valid  out  1      1-cycle pulse when dout updates
//   frame_err    out  1      1-cycle pulse on bad latch or timeout
//   frame_cnt    out  16     good frames since reset, wraps 0xFFFF->0
//   bit_cnt      out  CNT_W  bits shifted in the current frame
// BEHAVIOUR
//   Reset (RSTN low): dout=0, frame_valid=0, frame_err=0, frame_cnt=0, bit_cnt=0.
//     Shift register=0, timeout counter=0, FSM=IDLE.
//     Sync flops reset to sclk=0, sdat=0, sen=0, sclrn=1.
//     Reset is asynchronous. Asserting it mid-frame discards the partial frame.
//   Sampling: each link input passes through a 2-flop synchronizer plus one
//     edge-detect register. A link rising edge therefore acts 3 clk cycles after
//     the pin edge. sclk high and low times must each be >= 3 clk periods.
//   Shift: on a synced sclk rise, shreg <= {shreg[WIDTH-2:0], sdat_s}.
//     bit_cnt increments and saturates at WIDTH+1. sdat is sampled on that same
//     synced cycle.
//   FSM: IDLE (bit_cnt=0), SHIFT (1..WIDTH), OVER (>WIDTH).
//     IDLE->SHIFT on the first shift.
//     SHIFT->OVER on shift number WIDTH+1.
//     Any state->IDLE on latch, clear or timeout.
//   Latch: on a synced sen rise, if bit_cnt==WIDTH:
//     dout <= shreg, frame_valid=1 for 1 cycle, frame_cnt++.
//     Otherwise (including 0 bits, or OVER): frame_err=1 for 1 cycle and dout holds.
//     In both cases bit_cnt and shreg are cleared and FSM goes to IDLE.
//     dout and frame_valid update together, 3 clk cycles after the sen pin rises.
//   Simultaneous shift and latch in one cycle: the shift is applied first.
//     The latch then evaluates the new bit count and the new shreg contents.
//   Clear: while sclrn_s==0, shreg and bit_cnt are held at 0 and FSM=IDLE.
//     Shifts are ignored. dout and frame_cnt are untouched.
//     A sen rise while clear is active is ignored (no valid, no err).
//   Timeout: in SHIFT or OVER, the timeout counter counts cycles with no sclk rise.
//     Any sclk rise resets it to 0. On reaching TIMEOUT: frame_err pulses,
//     bit_cnt=0, shreg=0, FSM=IDLE. The counter is held at 0 in IDLE.
//   frame_valid and frame_err are never both 1 in the same cycle.
// TESTING
//   1. 64 bits of 0x0123456789ABCDEF MSB first, then sen pulse.
//      -> dout=0x0123456789ABCDEF, frame_valid 1 cycle at sen+3, frame_cnt=1.
//   2. 63 bits then sen.
//      -> frame_err 1 cycle, dout unchanged, frame_cnt unchanged, bit_cnt=0.
//   3. 65 bits then sen.
//      -> FSM hits OVER at bit 65, then frame_err, dout unchanged.
//      Then a clean 64-bit frame of all 1s -> dout=0xFFFF_FFFF_FFFF_FFFF.
//   4. 10 bits, sclrn low 5 cycles, then 64 bits of 0xA5A5... and sen.
//      -> dout=0xA5A5A5A5A5A5A5A5, frame_cnt increments by 1 only.
//   5. 20 bits then no activity for TIMEOUT cycles.
//      -> frame_err at TIMEOUT, bit_cnt=0. A later full frame latches correctly.
//   6. RSTN low mid-frame (bit 30), async to clk.
//      -> all outputs 0 immediately. Next full frame latches with frame_cnt=1.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Purpose: oversample a serial shift link (sclk/sdat/sen/sclrn) and rebuild MSB-first frames.
// Latency: dout/frame_valid/frame_err update 3 clk cycles after the sen pin rises.
// Backpressure: none; the link cannot be stalled, and malformed frames are flagged and dropped.
module serial_frame_rx #(
    parameter int WIDTH   = 64,
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             sclk,
    input  logic             sdat,
    input  logic             sen,
    input  logic             sclrn,
    output logic [WIDTH-1:0] dout,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sclk_sync, sen_sync;   // [1:0] synchronizer, [2] edge-detect
    logic [1:0]         sdat_sync, sclrn_sync;
    logic [WIDTH-1:0]   shreg, shreg_a, shreg_d;
    logic [CNT_W-1:0]   cnt_a, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               sclk_rise, sen_rise, sdat_s, sclrn_s;
    logic               shift, latch, latch_ok, tmo_hit, valid_d, err_d;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sen_rise  = sen_sync[1] & ~sen_sync[2];
    assign sdat_s    = sdat_sync[1];
    assign sclrn_s   = sclrn_sync[1];

    // Bring the asynchronous link wires into the clk domain.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sclk_sync  <= '0;
            sen_sync   <= '0;
            sdat_sync  <= '0;
            sclrn_sync <= 2'b11;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], sclk};
            sen_sync   <= {sen_sync[1:0], sen};
            sdat_sync  <= {sdat_sync[0], sdat};
            sclrn_sync <= {sclrn_sync[0], sclrn};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: shift is applied first so a same-cycle latch sees the updated frame.
    always_comb begin
        shift    = sclk_rise & sclrn_s;
        latch    = sen_rise & sclrn_s;
        shreg_a  = shreg;
        cnt_a    = bit_cnt;
        if (shift) begin
            shreg_a = {shreg[WIDTH-2:0], sdat_s};
            if (bit_cnt != CNT_MAX) cnt_a = bit_cnt + 1'b1;
        end
        latch_ok = latch && (cnt_a == CNT_FULL);
        tmo_hit  = (state_q != IDLE) && !shift && (tmo_q == TMO_LAST);

        state_d  = state_q;
        shreg_d  = shreg_a;
        cnt_d    = cnt_a;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (!sclrn_s) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (latch) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            valid_d = latch_ok;
            err_d   = !latch_ok;
        end else if (tmo_hit) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else if (shift) begin
            state_d = (cnt_a > CNT_FULL) ? OVER : SHIFT;
        end
        // Idle timer only runs inside a partial frame; any shift restarts it.
        tmo_d = (state_d == IDLE || shift) ? '0 : tmo_q + 1'b1;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            tmo_q       <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            shreg       <= shreg_d;
            bit_cnt     <= cnt_d;
            tmo_q       <= tmo_d;
            frame_valid <= valid_d;
            frame_err   <= err_d;
            if (valid_d) begin
                dout      <= shreg_a;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
